// File: rtl/morra_partita_ctrl.sv
// Morra Cinese match controller: loads the match length on INIZIA, scores one
// round per cycle, enforces the no-repeat-of-winning-move rule, declares the result.
module morra_partita_ctrl #(
    parameter int MIN_MANCHE = 4,
    parameter int VANTAGGIO  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] PRIMO,
    input  logic [1:0] SECONDO,
    input  logic       INIZIA,
    output logic [1:0] MANCHE,
    output logic [1:0] PARTITA,
    output logic [4:0] NUM_MANCHE
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GIOCO = 2'b01,
        FINE  = 2'b10
    } stato_t;

    localparam logic [1:0] NESSUNO  = 2'b00;
    localparam logic [1:0] VINCE_P  = 2'b01;
    localparam logic [1:0] VINCE_S  = 2'b10;
    localparam logic [1:0] PAREGGIO = 2'b11;

    localparam logic [4:0] MIN_W  = MIN_MANCHE[4:0];
    localparam logic [4:0] VANT_W = VANTAGGIO[4:0];

    // Round resolution for two non-zero moves: carta>sasso, forbice>carta, sasso>forbice.
    function automatic logic [1:0] risolvi(input logic [1:0] p, input logic [1:0] s);
        logic [1:0] r;
        if (p == s) begin
            r = PAREGGIO;
        end else if ((p == 2'b10 && s == 2'b01) ||
                     (p == 2'b11 && s == 2'b10) ||
                     (p == 2'b01 && s == 2'b11)) begin
            r = VINCE_P;
        end else begin
            r = VINCE_S;
        end
        return r;
    endfunction

    stato_t     stato_q, stato_d;
    logic [4:0] max_q, max_d;
    logic [4:0] num_q, num_d;
    logic [4:0] vinte1_q, vinte1_d;
    logic [4:0] vinte2_q, vinte2_d;
    logic [1:0] vieto_chi_q, vieto_chi_d;
    logic [1:0] vieto_mossa_q, vieto_mossa_d;
    logic [1:0] manche_q, manche_d;
    logic [1:0] partita_q, partita_d;

    logic       valida_s;
    logic [1:0] esito_s;
    logic [4:0] vantaggio_s;

    // Restricted player repeating the stored winning move makes the round invalid.
    assign valida_s = (PRIMO != 2'b00) && (SECONDO != 2'b00) &&
                      !(vieto_chi_q == VINCE_P && PRIMO   == vieto_mossa_q) &&
                      !(vieto_chi_q == VINCE_S && SECONDO == vieto_mossa_q);
    assign esito_s  = risolvi(PRIMO, SECONDO);

    // Next-state, scoring and end-of-match decision.
    always_comb begin
        stato_d       = stato_q;
        max_d         = max_q;
        num_d         = num_q;
        vinte1_d      = vinte1_q;
        vinte2_d      = vinte2_q;
        vieto_chi_d   = vieto_chi_q;
        vieto_mossa_d = vieto_mossa_q;
        manche_d      = NESSUNO;
        partita_d     = partita_q;
        vantaggio_s   = 5'd0;

        if (INIZIA) begin
            stato_d       = GIOCO;
            max_d         = MIN_W + {1'b0, PRIMO, SECONDO};
            num_d         = 5'd0;
            vinte1_d      = 5'd0;
            vinte2_d      = 5'd0;
            vieto_chi_d   = NESSUNO;
            vieto_mossa_d = 2'b00;
            partita_d     = NESSUNO;
        end else begin
            case (stato_q)
                GIOCO: begin
                    if (valida_s) begin
                        manche_d = esito_s;
                        num_d    = num_q + 5'd1;
                        case (esito_s)
                            VINCE_P: begin
                                vinte1_d      = vinte1_q + 5'd1;
                                vieto_chi_d   = VINCE_P;
                                vieto_mossa_d = PRIMO;
                            end
                            VINCE_S: begin
                                vinte2_d      = vinte2_q + 5'd1;
                                vieto_chi_d   = VINCE_S;
                                vieto_mossa_d = SECONDO;
                            end
                            default: begin
                                vieto_chi_d   = NESSUNO;
                                vieto_mossa_d = 2'b00;
                            end
                        endcase

                        // Unsigned larger-minus-smaller, so no sign wrap.
                        vantaggio_s = (vinte1_d >= vinte2_d) ? (vinte1_d - vinte2_d)
                                                             : (vinte2_d - vinte1_d);

                        if ((num_d >= MIN_W) && (vantaggio_s >= VANT_W)) begin
                            partita_d = (vinte1_d > vinte2_d) ? VINCE_P : VINCE_S;
                            stato_d   = FINE;
                        end else if (num_d == max_q) begin
                            partita_d = (vinte1_d > vinte2_d) ? VINCE_P :
                                        (vinte2_d > vinte1_d) ? VINCE_S : PAREGGIO;
                            stato_d   = FINE;
                        end else begin
                            stato_d = GIOCO;
                        end
                    end else begin
                        manche_d = NESSUNO;
                    end
                end
                IDLE, FINE: begin
                    manche_d = NESSUNO;
                end
                default: begin
                    stato_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stato_q       <= IDLE;
            max_q         <= 5'd0;
            num_q         <= 5'd0;
            vinte1_q      <= 5'd0;
            vinte2_q      <= 5'd0;
            vieto_chi_q   <= NESSUNO;
            vieto_mossa_q <= 2'b00;
            manche_q      <= NESSUNO;
            partita_q     <= NESSUNO;
        end else begin
            stato_q       <= stato_d;
            max_q         <= max_d;
            num_q         <= num_d;
            vinte1_q      <= vinte1_d;
            vinte2_q      <= vinte2_d;
            vieto_chi_q   <= vieto_chi_d;
            vieto_mossa_q <= vieto_mossa_d;
            manche_q      <= manche_d;
            partita_q     <= partita_d;
        end
    end

    assign MANCHE     = manche_q;
    assign PARTITA    = partita_q;
    assign NUM_MANCHE = num_q;

endmodule
